noc_out_port_arb: RTL and testbench



---
 rtl/noc_arb_pkg.sv | 14 +
 rtl/noc_rr_arb.sv | 36 +++
 rtl/noc_out_port_arb.sv | 160 ++++++++++++++++
 tb/tb_noc_out_port_arb.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_arb_pkg.sv
// Shared constants and state type for the NoC output-port arbiter.
// The flit field positions are defaults; the top may override them per instance.
package noc_arb_pkg;

  localparam int NOC_FLIT_W  = 64;
  localparam int NOC_LEN_LSB = 22;
  localparam int NOC_LEN_W   = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BODY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/noc_rr_arb.sv
// Combinational round-robin picker: grants the first requester found at or after
// i_ptr, wrapping from NUM_IN-1 back to 0.
module noc_rr_arb #(
  parameter  int NUM_IN = 4,
  localparam int IDX_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] i_req,
  input  logic [IDX_W-1:0]  i_ptr,
  output logic [NUM_IN-1:0] o_gnt,
  output logic [IDX_W-1:0]  o_gnt_idx
);

  int               w_sum;
  logic [IDX_W-1:0] w_j;
  logic             w_hit;
  logic             w_found;

  // Walk the sources in priority order starting at the pointer; the first hit wins.
  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    w_sum     = 0;
    w_j       = '0;
    w_hit     = 1'b0;
    w_found   = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      w_sum      = int'(i_ptr) + k;
      w_j        = IDX_W'((w_sum >= NUM_IN) ? (w_sum - NUM_IN) : w_sum);
      w_hit      = !w_found && i_req[w_j];
      o_gnt[w_j] = o_gnt[w_j] | w_hit;
      o_gnt_idx  = w_hit ? w_j : o_gnt_idx;
      w_found    = w_found | w_hit;
    end
  end

endmodule

// File: rtl/noc_out_port_arb.sv
// Wormhole output-port arbiter: packet-granular round-robin onto one NoC link,
// locked to the owner until its tail flit, with valid/yummy credit flow control.
module noc_out_port_arb
  import noc_arb_pkg::*;
#(
  parameter  int NUM_IN  = 4,
  parameter  int FLIT_W  = NOC_FLIT_W,
  parameter  int LEN_LSB = NOC_LEN_LSB,
  parameter  int LEN_W   = NOC_LEN_W,
  parameter  int CREDITS = 4,
  localparam int IDX_W   = $clog2(NUM_IN),
  localparam int CNT_W   = $clog2(CREDITS + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN-1:0]        in_val,
  input  logic [NUM_IN*FLIT_W-1:0] in_data,
  output logic [NUM_IN-1:0]        in_rdy,
  output logic                     out_val,
  output logic [FLIT_W-1:0]        out_data,
  input  logic                     out_yummy,
  output logic                     busy,
  output logic [IDX_W-1:0]         owner,
  output logic [CNT_W-1:0]         credit_cnt,
  output logic                     credit_err
);

  arb_state_e        r_state;
  logic [IDX_W-1:0]  r_ptr;
  logic [IDX_W-1:0]  r_owner;
  logic [LEN_W-1:0]  r_remaining;
  logic              r_busy;
  logic [CNT_W-1:0]  r_credit_cnt;
  logic              r_credit_err;
  logic              r_out_val;
  logic [FLIT_W-1:0] r_out_data;

  logic [NUM_IN-1:0] w_gnt;
  logic [IDX_W-1:0]  w_gnt_idx;
  logic [NUM_IN-1:0] w_rdy;
  logic              w_acc;
  logic              w_credit_ok;
  logic [IDX_W-1:0]  w_sel;
  logic [FLIT_W-1:0] w_in_flit [NUM_IN];
  logic [FLIT_W-1:0] w_flit;
  logic [LEN_W-1:0]  w_len;

  function automatic logic [IDX_W-1:0] f_next(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(NUM_IN - 1)) ? '0 : (idx + IDX_W'(1));
  endfunction

  noc_rr_arb #(
    .NUM_IN (NUM_IN)
  ) u_rr (
    .i_req     (in_val),
    .i_ptr     (r_ptr),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx)
  );

  for (genvar g = 0; g < NUM_IN; g++) begin : g_split
    assign w_in_flit[g] = in_data[g*FLIT_W +: FLIT_W];
  end

  assign w_credit_ok = (r_credit_cnt != '0);

  // Idle offers the link to the RR winner; a locked link is offered only to its owner.
  always_comb begin
    w_rdy = '0;
    case (r_state)
      IDLE:    w_rdy = w_credit_ok ? w_gnt : '0;
      BODY:    w_rdy[r_owner] = w_credit_ok;
      default: w_rdy = '0;
    endcase
  end

  assign in_rdy = w_rdy;
  assign w_acc  = |(in_val & w_rdy);
  assign w_sel  = (r_state == BODY) ? r_owner : w_gnt_idx;
  assign w_flit = w_in_flit[w_sel];
  assign w_len  = w_flit[LEN_LSB +: LEN_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_val  <= 1'b0;
      r_out_data <= '0;
    end else begin
      r_out_val  <= w_acc;
      r_out_data <= w_acc ? w_flit : r_out_data;
    end
  end

  // A yummy arriving with the counter already full is a downstream protocol error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_credit_cnt <= CNT_W'(CREDITS);
      r_credit_err <= 1'b0;
    end else begin
      case ({w_acc, out_yummy})
        2'b10: r_credit_cnt <= r_credit_cnt - CNT_W'(1);
        2'b01: begin
          if (r_credit_cnt == CNT_W'(CREDITS)) begin
            r_credit_err <= 1'b1;
          end else begin
            r_credit_cnt <= r_credit_cnt + CNT_W'(1);
          end
        end
        default: r_credit_cnt <= r_credit_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_owner     <= '0;
      r_remaining <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_acc) begin
            r_owner <= w_gnt_idx;
            if (w_len == '0) begin
              r_ptr <= f_next(w_gnt_idx);
            end else begin
              r_state     <= BODY;
              r_remaining <= w_len;
              r_busy      <= 1'b1;
            end
          end
        end
        BODY: begin
          if (w_acc) begin
            if (r_remaining == LEN_W'(1)) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_ptr   <= f_next(r_owner);
            end else begin
              r_remaining <= r_remaining - LEN_W'(1);
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign out_val    = r_out_val;
  assign out_data   = r_out_data;
  assign busy       = r_busy;
  assign owner      = r_owner;
  assign credit_cnt = r_credit_cnt;
  assign credit_err = r_credit_err;

endmodule

// File: tb/tb_noc_out_port_arb.sv
// Bench for noc_out_port_arb: packet-level reference model checked every cycle,
// plus directed scenarios with hand-computed grant sequences and counter values.
module tb_noc_out_port_arb;

  localparam int N  = 4;
  localparam int FW = 64;
  localparam int CR = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  in_val = '0;
  logic [N*FW-1:0] in_data = '0;
  logic [N-1:0]  in_rdy;
  logic          out_val;
  logic [FW-1:0] out_data;
  logic          out_yummy = 1'b0;
  logic          busy;
  logic [1:0]    owner;
  logic [2:0]    credit_cnt;
  logic          credit_err;

  noc_out_port_arb #(
    .NUM_IN (N), .FLIT_W (FW), .LEN_LSB (22), .LEN_W (8), .CREDITS (CR)
  ) dut (
    .clk (clk), .rst (rst), .in_val (in_val), .in_data (in_data), .in_rdy (in_rdy),
    .out_val (out_val), .out_data (out_data), .out_yummy (out_yummy), .busy (busy),
    .owner (owner), .credit_cnt (credit_cnt), .credit_err (credit_err)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: link owner, body flits still owed, credits, RR pointer
  int          m_ptr, m_owner, m_left, m_credits;
  logic        m_out_val, m_err;
  logic [63:0] m_out_data;

  function automatic logic [N-1:0] exp_rdy();
    logic [N-1:0] r;
    r = '0;
    if (m_credits == 0) return r;
    if (m_left > 0) begin
      r[m_owner] = 1'b1;
      return r;
    end
    for (int k = 0; k < N; k++) begin
      if (in_val[(m_ptr + k) % N]) begin
        r[(m_ptr + k) % N] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  function automatic int src_of(input logic [N-1:0] a);
    for (int k = 0; k < N; k++) if (a[k]) return k;
    return -1;
  endfunction

  function automatic logic [63:0] flit_of(input int s);
    return in_data[s*FW +: FW];
  endfunction

  function automatic int len_of(input int s);
    logic [63:0] f;
    f = flit_of(s);
    return int'(f[22 +: 8]);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ptr <= 0; m_owner <= 0; m_left <= 0; m_credits <= CR;
      m_out_val <= 1'b0; m_out_data <= '0; m_err <= 1'b0;
    end else begin
      m_out_val <= ((in_val & exp_rdy()) != '0);
      if ((in_val & exp_rdy()) != '0) begin
        m_out_data <= flit_of(src_of(in_val & exp_rdy()));
        if (m_left == 0) begin
          m_owner <= src_of(in_val & exp_rdy());
          if (len_of(src_of(in_val & exp_rdy())) == 0)
            m_ptr <= (src_of(in_val & exp_rdy()) + 1) % N;
          else
            m_left <= len_of(src_of(in_val & exp_rdy()));
        end else begin
          m_left <= m_left - 1;
          if (m_left == 1) m_ptr <= (m_owner + 1) % N;
        end
      end
      if (out_yummy && ((in_val & exp_rdy()) == '0) && m_credits == CR)
        m_err <= 1'b1;
      else
        m_credits <= m_credits - int'((in_val & exp_rdy()) != '0) + int'(out_yummy);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("in_rdy", 64'(in_rdy), 64'(exp_rdy()));
      cmp("out_val", 64'(out_val), 64'(m_out_val));
      if (m_out_val) cmp("out_data", out_data, m_out_data);
      cmp("busy", 64'(busy), 64'(m_left != 0));
      cmp("owner", 64'(owner), 64'(m_owner));
      cmp("credit_cnt", 64'(credit_cnt), 64'(m_credits));
      cmp("credit_err", 64'(credit_err), 64'(m_err));
    end
  end

  // Source-side driver: per-source flit queues, popped on observed handshake
  logic [63:0] srcq [N][$];
  logic [N-1:0] en = '1;
  int cyc_log[$];

  function automatic logic [63:0] hdr(input int s, input int l, input int tag);
    logic [63:0] f;
    f = 64'h0;
    f[63:56] = 8'hA0 + 8'(s);
    f[22 +: 8] = 8'(l);
    f[7:0] = 8'(tag);
    return f;
  endfunction

  function automatic logic [63:0] body(input int s, input int n);
    logic [63:0] f;
    f = 64'h0000_0000_3FC0_0000;
    f[63:56] = 8'hB0 + 8'(s);
    f[15:0] = 16'(n);
    return f;
  endfunction

  task automatic tick(input logic y);
    logic [N-1:0] a;
    for (int i = 0; i < N; i++) begin
      in_val[i] = en[i] && (srcq[i].size() > 0);
      in_data[i*FW +: FW] = in_val[i] ? srcq[i][0] : 64'h0;
    end
    out_yummy = y;
    @(negedge clk);
    a = in_val & in_rdy;
    cyc_log.push_back(src_of(a));
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (a[i]) void'(srcq[i].pop_front());
  endtask

  task automatic check_log(input string nm, input int n, input int e[8]);
    cmp({nm, "_cycles"}, 64'(cyc_log.size()), 64'(n));
    for (int i = 0; i < n && i < cyc_log.size(); i++) cmp(nm, 64'(cyc_log[i]), 64'(e[i]));
    cyc_log.delete();
  endtask

  task automatic clear_queues();
    for (int i = 0; i < N; i++) srcq[i].delete();
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    tick(1'b0);
    tick(1'b0);
    rst = 1'b0;
    chk_en = 1'b1;
    cmp("rst_out_val", 64'(out_val), 64'd0);
    cmp("rst_out_data", out_data, 64'd0);
    cmp("rst_busy", 64'(busy), 64'd0);
    cmp("rst_owner", 64'(owner), 64'd0);
    cmp("rst_credit_cnt", 64'(credit_cnt), 64'd4);
    cmp("rst_credit_err", 64'(credit_err), 64'd0);
    cyc_log.delete();

    // src0: header L=2 plus two body flits, no credits returned
    srcq[0].push_back(hdr(0, 2, 1));
    srcq[0].push_back(body(0, 1));
    srcq[0].push_back(body(0, 2));
    tick(1'b0);
    cmp("t1_busy_after_hdr", 64'(busy), 64'd1);
    tick(1'b0); tick(1'b0); tick(1'b0); tick(1'b0);
    check_log("t1_grants", 5, '{0, 0, 0, -1, -1, 0, 0, 0});
    cmp("t1_credit_cnt", 64'(credit_cnt), 64'd1);
    cmp("t1_busy", 64'(busy), 64'd0);
    tick(1'b1); tick(1'b1); tick(1'b1);
    cmp("t1_credits_back", 64'(credit_cnt), 64'd4);
    rst = 1'b1;
    tick(1'b0);
    rst = 1'b0;
    cyc_log.delete();

    // Four single-flit sources, yummy every cycle: back-to-back RR order
    srcq[0].push_back(hdr(0, 0, 2));
    srcq[0].push_back(hdr(0, 0, 3));
    srcq[1].push_back(hdr(1, 0, 4));
    srcq[2].push_back(hdr(2, 0, 5));
    srcq[3].push_back(hdr(3, 0, 6));
    for (int i = 0; i < 5; i++) tick(1'b1);
    check_log("t2_grants", 5, '{0, 1, 2, 3, 0, 0, 0, 0});
    cmp("t2_credit_cnt", 64'(credit_cnt), 64'd4);
    tick(1'b0);
    cyc_log.delete();

    // src1 holds the lock for L=3; src2 must wait, then gets the very next cycle
    srcq[1].push_back(hdr(1, 3, 7));
    for (int i = 1; i <= 3; i++) srcq[1].push_back(body(1, i));
    srcq[2].push_back(hdr(2, 0, 8));
    for (int i = 0; i < 5; i++) tick(1'b1);
    check_log("t3_grants", 5, '{1, 1, 1, 1, 2, 0, 0, 0});
    cmp("t3_credit_err", 64'(credit_err), 64'd0);
    tick(1'b0);
    cyc_log.delete();

    // Credit starvation: 6-flit packet, only 4 credits
    srcq[0].push_back(hdr(0, 5, 9));
    for (int i = 1; i <= 5; i++) srcq[0].push_back(body(0, i));
    for (int i = 0; i < 6; i++) tick(1'b0);
    check_log("t4_grants", 6, '{0, 0, 0, 0, -1, -1, 0, 0});
    cmp("t4_credit_zero", 64'(credit_cnt), 64'd0);
    cmp("t4_rdy_zero", 64'(in_rdy), 64'd0);
    tick(1'b1); tick(1'b0); tick(1'b0); tick(1'b0);
    check_log("t4_one_more", 4, '{-1, 0, -1, -1, 0, 0, 0, 0});
    cmp("t4_still_busy", 64'(busy), 64'd1);

    // Accept+yummy at 2 holds; yummy at full sets the sticky error
    en = 4'b1110;
    tick(1'b1); tick(1'b1);
    cmp("t5_credit_two", 64'(credit_cnt), 64'd2);
    en = 4'b1111;
    tick(1'b1);
    cmp("t5_acc_yummy_hold", 64'(credit_cnt), 64'd2);
    cmp("t5_tail_unlock", 64'(busy), 64'd0);
    tick(1'b1); tick(1'b1);
    cmp("t5_full", 64'(credit_cnt), 64'd4);
    cmp("t5_no_err_yet", 64'(credit_err), 64'd0);
    tick(1'b1);
    cmp("t5_overflow_err", 64'(credit_err), 64'd1);
    cmp("t5_overflow_hold", 64'(credit_cnt), 64'd4);
    tick(1'b0);
    cyc_log.delete();

    // Reset in the middle of a body (remaining=5)
    srcq[1].push_back(hdr(1, 7, 10));
    for (int i = 1; i <= 7; i++) srcq[1].push_back(body(1, i));
    tick(1'b1); tick(1'b1); tick(1'b1);
    check_log("t6_pre", 3, '{1, 1, 1, 0, 0, 0, 0, 0});
    cmp("t6_busy_mid", 64'(busy), 64'd1);
    rst = 1'b1;
    tick(1'b0);
    rst = 1'b0;
    clear_queues();
    cmp("t6_out_val", 64'(out_val), 64'd0);
    cmp("t6_busy", 64'(busy), 64'd0);
    cmp("t6_credit_cnt", 64'(credit_cnt), 64'd4);
    cmp("t6_owner", 64'(owner), 64'd0);
    cmp("t6_credit_err", 64'(credit_err), 64'd0);
    cyc_log.delete();
    srcq[0].push_back(hdr(0, 0, 11));
    srcq[3].push_back(hdr(3, 0, 12));
    tick(1'b0); tick(1'b0); tick(1'b0);
    check_log("t6_fresh", 3, '{0, 3, -1, 0, 0, 0, 0, 0});
    cmp("t6_credit_end", 64'(credit_cnt), 64'd2);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
